// File: rtl/ucsbece154b_icache.sv
// Direct-mapped, read-only instruction cache for the fetch stage.
// Hits are answered combinationally; misses refill a whole line from memory
// over a one-cycle request pulse followed by BLOCK_WORDS data beats.
//
// state | meaning
// IDLE  | look up PCF_i; hit returns data, miss latches the line and requests it
// REQ   | request pulse to memory, beat counter cleared
// FILL  | collecting beats into the latched line; last beat validates it
module ucsbece154b_icache #(
  parameter int unsigned NUM_SETS    = 8,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF_i,
  output logic        ReadyF_o,
  output logic [31:0] InstrF_o,
  output logic        MemReadRequest_o,
  output logic [31:0] MemReadAddress_o,
  input  logic        MemDataReady_i,
  input  logic [31:0] MemDataIn_i
);

  localparam int unsigned OFF_W   = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_W   = $clog2(NUM_SETS);
  localparam int unsigned TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int unsigned TAG_W   = 32 - TAG_LSB;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t state, state_next;

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [31:0]         data_q [NUM_SETS][BLOCK_WORDS];

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [OFF_W-1:0] beat_cnt;
  logic             hit;
  logic             beat_en;
  logic             last_beat;

  assign pc_off = PCF_i[2 +: OFF_W];
  assign pc_idx = PCF_i[2 + OFF_W +: IDX_W];
  assign pc_tag = PCF_i[31:TAG_LSB];

  assign hit       = (state == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign beat_en   = (state == FILL) && MemDataReady_i;
  assign last_beat = beat_en && (beat_cnt == LAST_BEAT);

  assign ReadyF_o         = hit;
  assign InstrF_o         = hit ? data_q[pc_idx][pc_off] : NOP;
  assign MemReadRequest_o = (state == REQ);

  // State register; reset aborts any refill in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!hit) state_next = REQ;
      REQ:     state_next = FILL;
      FILL:    if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Miss bookkeeping, beat counter and valid bits (the only reset storage).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q          <= '0;
      fill_idx         <= '0;
      fill_tag         <= '0;
      beat_cnt         <= '0;
      MemReadAddress_o <= '0;
    end else begin
      case (state)
        IDLE: if (!hit) begin
          fill_idx         <= pc_idx;
          fill_tag         <= pc_tag;
          MemReadAddress_o <= {PCF_i[31:OFF_W+2], {(OFF_W+2){1'b0}}};
        end
        REQ:  beat_cnt <= '0;
        FILL: if (beat_en) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (last_beat) valid_q[fill_idx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays; written only while filling, so no reset is needed.
  always_ff @(posedge clk) begin
    if (beat_en) begin
      data_q[fill_idx][beat_cnt] <= MemDataIn_i;
      if (last_beat) tag_q[fill_idx] <= fill_tag;
    end
  end

endmodule
